// File: rtl/vga_timing_gen.sv
// Runtime-programmable VGA/DVI raster timing generator with double-buffered timing
// fields that switch over at a frame boundary and a pixel-clock enable.
module vga_timing_gen #(
  parameter int CNT_W        = 12,
  parameter int HACTIVE_INIT = 640,
  parameter int HFP_INIT     = 16,
  parameter int HSYN_INIT    = 96,
  parameter int HBP_INIT     = 48,
  parameter int VACTIVE_INIT = 480,
  parameter int VFP_INIT     = 10,
  parameter int VSYN_INIT    = 2,
  parameter int VBP_INIT     = 33,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_pixEn,
  input  logic             i_cfgWe,
  input  logic [2:0]       i_cfgAddr,
  input  logic [CNT_W-1:0] i_cfgData,
  input  logic             i_cfgCommit,
  output logic             o_cfgPending,
  output logic             o_hSync,
  output logic             o_vSync,
  output logic             o_de,
  output logic             o_lineStart,
  output logic             o_frameStart,
  output logic [CNT_W-1:0] o_hCnt,
  output logic [CNT_W-1:0] o_vCnt
);
  localparam int TW = CNT_W + 2;
  typedef logic [CNT_W-1:0] fld_t;
  typedef logic [TW-1:0]    wide_t;
  localparam logic DE_RST = (HACTIVE_INIT > 0) && (VACTIVE_INIT > 0);
  localparam fld_t ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam wide_t ONE_W = {{(TW-1){1'b0}}, 1'b1};

  function automatic fld_t init_val(input logic [2:0] idx);
    case (idx)
      3'd0:    init_val = fld_t'(HACTIVE_INIT);
      3'd1:    init_val = fld_t'(HFP_INIT);
      3'd2:    init_val = fld_t'(HSYN_INIT);
      3'd3:    init_val = fld_t'(HBP_INIT);
      3'd4:    init_val = fld_t'(VACTIVE_INIT);
      3'd5:    init_val = fld_t'(VFP_INIT);
      3'd6:    init_val = fld_t'(VSYN_INIT);
      3'd7:    init_val = fld_t'(VBP_INIT);
      default: init_val = {CNT_W{1'b0}};
    endcase
  endfunction

  function automatic wide_t wide(input fld_t f);
    wide = {2'b00, f};
  endfunction

  fld_t  pend_r [8];
  fld_t  act_r [8];
  fld_t  act_nxt_s [8];
  logic  pend_flag_r;
  fld_t  hcnt_r, vcnt_r, hcnt_nxt_s, vcnt_nxt_s;
  wide_t htot_s, vtot_s;
  logic  h_last_s, v_last_s, wrap_s, apply_s;
  logic  de_nxt_s, hs_act_s, vs_act_s;
  logic  hsync_r, vsync_r, de_r, line_start_r, frame_start_r;

  // Line/frame length of the running set; zero totals count as "always last"
  always_comb begin
    htot_s   = wide(act_r[0]) + wide(act_r[1]) + wide(act_r[2]) + wide(act_r[3]);
    vtot_s   = wide(act_r[4]) + wide(act_r[5]) + wide(act_r[6]) + wide(act_r[7]);
    h_last_s = (htot_s == {TW{1'b0}}) || (wide(hcnt_r) >= htot_s - ONE_W);
    v_last_s = (vtot_s == {TW{1'b0}}) || (wide(vcnt_r) >= vtot_s - ONE_W);
    wrap_s   = i_pixEn && h_last_s && v_last_s;
    apply_s  = wrap_s && (pend_flag_r || i_cfgCommit);
  end

  // Next raster position
  always_comb begin
    hcnt_nxt_s = hcnt_r;
    vcnt_nxt_s = vcnt_r;
    if (i_pixEn) begin
      if (h_last_s) begin
        hcnt_nxt_s = {CNT_W{1'b0}};
        if (v_last_s) begin
          vcnt_nxt_s = {CNT_W{1'b0}};
        end else begin
          vcnt_nxt_s = vcnt_r + ONE_C;
        end
      end else begin
        hcnt_nxt_s = hcnt_r + ONE_C;
      end
    end else begin
      hcnt_nxt_s = hcnt_r;
      vcnt_nxt_s = vcnt_r;
    end
  end

  // Decode the next position with the set that will be active there
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (apply_s) begin
        act_nxt_s[i] = pend_r[i];
      end else begin
        act_nxt_s[i] = act_r[i];
      end
    end
    de_nxt_s = (wide(hcnt_nxt_s) < wide(act_nxt_s[0])) && (wide(vcnt_nxt_s) < wide(act_nxt_s[4]));
    hs_act_s = (wide(hcnt_nxt_s) >= wide(act_nxt_s[0]) + wide(act_nxt_s[1])) &&
               (wide(hcnt_nxt_s) <  wide(act_nxt_s[0]) + wide(act_nxt_s[1]) + wide(act_nxt_s[2]));
    vs_act_s = (wide(vcnt_nxt_s) >= wide(act_nxt_s[4]) + wide(act_nxt_s[5])) &&
               (wide(vcnt_nxt_s) <  wide(act_nxt_s[4]) + wide(act_nxt_s[5]) + wide(act_nxt_s[6]));
  end

  // Pending set: software writes land here without touching the running frame
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      for (int i = 0; i < 8; i++) pend_r[i] <= init_val(3'(i));
    end else if (i_cfgWe) begin
      pend_r[i_cfgAddr] <= i_cfgData;
    end else begin
      pend_r <= pend_r;
    end
  end

  // Active set and commit request flag
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      for (int i = 0; i < 8; i++) act_r[i] <= init_val(3'(i));
      pend_flag_r <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) act_r[i] <= act_nxt_s[i];
      if (apply_s) begin
        pend_flag_r <= 1'b0;
      end else if (i_cfgCommit) begin
        pend_flag_r <= 1'b1;
      end else begin
        pend_flag_r <= pend_flag_r;
      end
    end
  end

  // Counters, level outputs and start pulses
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      hcnt_r        <= {CNT_W{1'b0}};
      vcnt_r        <= {CNT_W{1'b0}};
      hsync_r       <= !HSYNC_POL;
      vsync_r       <= !VSYNC_POL;
      de_r          <= DE_RST;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      line_start_r  <= i_pixEn && h_last_s;
      frame_start_r <= wrap_s;
      if (i_pixEn) begin
        hcnt_r  <= hcnt_nxt_s;
        vcnt_r  <= vcnt_nxt_s;
        hsync_r <= hs_act_s ? HSYNC_POL : !HSYNC_POL;
        vsync_r <= vs_act_s ? VSYNC_POL : !VSYNC_POL;
        de_r    <= de_nxt_s;
      end else begin
        hcnt_r  <= hcnt_r;
        vcnt_r  <= vcnt_r;
        hsync_r <= hsync_r;
        vsync_r <= vsync_r;
        de_r    <= de_r;
      end
    end
  end

  assign o_cfgPending = pend_flag_r;
  assign o_hSync      = hsync_r;
  assign o_vSync      = vsync_r;
  assign o_de         = de_r;
  assign o_lineStart  = line_start_r;
  assign o_frameStart = frame_start_r;
  assign o_hCnt       = hcnt_r;
  assign o_vCnt       = vcnt_r;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: a default-VGA instance checked against position-from-cycle arithmetic, and a
// small-init active-high instance checked against a field-level reference model.
module tb_vga_timing_gen;
  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVA = 6, SVF = 1, SVS = 2, SVB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d_arst, d_pix, d_we, d_commit, d_pend, d_hs, d_vs, d_de, d_ls, d_fs;
  logic [2:0]  d_addr;
  logic [11:0] d_data, d_h, d_v;
  logic        s_arst, s_pix, s_we, s_commit, s_pend, s_hs, s_vs, s_de, s_ls, s_fs;
  logic [2:0]  s_addr;
  logic [11:0] s_data, s_h, s_v;

  vga_timing_gen u_def (
    .i_clk(clk), .i_arst(d_arst), .i_pixEn(d_pix), .i_cfgWe(d_we), .i_cfgAddr(d_addr),
    .i_cfgData(d_data), .i_cfgCommit(d_commit), .o_cfgPending(d_pend), .o_hSync(d_hs),
    .o_vSync(d_vs), .o_de(d_de), .o_lineStart(d_ls), .o_frameStart(d_fs),
    .o_hCnt(d_h), .o_vCnt(d_v)
  );

  vga_timing_gen #(
    .CNT_W(12), .HACTIVE_INIT(SHA), .HFP_INIT(SHF), .HSYN_INIT(SHS), .HBP_INIT(SHB),
    .VACTIVE_INIT(SVA), .VFP_INIT(SVF), .VSYN_INIT(SVS), .VBP_INIT(SVB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_sml (
    .i_clk(clk), .i_arst(s_arst), .i_pixEn(s_pix), .i_cfgWe(s_we), .i_cfgAddr(s_addr),
    .i_cfgData(s_data), .i_cfgCommit(s_commit), .o_cfgPending(s_pend), .o_hSync(s_hs),
    .o_vSync(s_vs), .o_de(s_de), .o_lineStart(s_ls), .o_frameStart(s_fs),
    .o_hCnt(s_h), .o_vCnt(s_v)
  );

  int tests = 0;
  int fails = 0;

  // reference model state for u_sml
  int mh, mv, mp[8], ma[8];
  bit mflag, e_hs, e_vs, e_de, e_ls, e_fs;

  function automatic logic [29:0] pk(input int h, input int v, input bit hs, input bit vs,
                                     input bit de, input bit ls, input bit fs, input bit pend);
    pk = {h[11:0], v[11:0], hs, vs, de, ls, fs, pend};
  endfunction

  // default VGA timing: position is simply the step count modulo 800 x 525
  function automatic logic [29:0] def_exp(input int k, input bit pend);
    int h, v;
    h = k % 800;
    v = (k / 800) % 525;
    def_exp = pk(h, v, !(h >= 656 && h < 752), !(v >= 490 && v < 492),
                 (h < 640) && (v < 480), (k > 0) && (h == 0), (k > 0) && (k % 420000 == 0), pend);
  endfunction

  task automatic check(input string tag, input logic [29:0] obs, input logic [29:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h (h,v,hs,vs,de,ls,fs,pend)", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mp = '{SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB};
    ma = mp;
    mh = 0; mv = 0; mflag = 0;
    e_de = (SHA > 0) && (SVA > 0);
    e_hs = 1'b0; e_vs = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
  endtask

  task automatic model_step(input bit pix, input bit we, input int addr, input int data,
                            input bit commit);
    int ht, vt;
    bit lw, fw;
    ht = ma[0] + ma[1] + ma[2] + ma[3];
    vt = ma[4] + ma[5] + ma[6] + ma[7];
    lw = pix && (mh + 1 >= ht);
    fw = lw && (mv + 1 >= vt);
    e_ls = lw;
    e_fs = fw;
    if (fw && (mflag || commit)) begin
      ma = mp;
      mflag = 0;
    end else if (commit) begin
      mflag = 1;
    end
    if (we) mp[addr] = data;
    if (pix) begin
      if (lw) begin
        mh = 0;
        mv = fw ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      e_de = (mh < ma[0]) && (mv < ma[4]);
      e_hs = (mh >= ma[0] + ma[1]) && (mh < ma[0] + ma[1] + ma[2]);
      e_vs = (mv >= ma[4] + ma[5]) && (mv < ma[4] + ma[5] + ma[6]);
    end
  endtask

  task automatic sml_cmp(input string tag);
    check(tag, {s_h, s_v, s_hs, s_vs, s_de, s_ls, s_fs, s_pend},
          pk(mh, mv, e_hs, e_vs, e_de, e_ls, e_fs, mflag));
  endtask

  // one clock of u_sml: drive at negedge, model at posedge, compare at next negedge
  task automatic cyc(input logic pix, input logic we, input logic [2:0] addr,
                     input logic [11:0] data, input logic commit, input string tag);
    s_pix = pix; s_we = we; s_addr = addr; s_data = data; s_commit = commit;
    @(posedge clk);
    model_step(pix, we, int'(addr), int'(data), commit);
    @(negedge clk);
    sml_cmp(tag);
    s_pix = 1'b0; s_we = 1'b0; s_commit = 1'b0;
  endtask

  initial begin
    int tiny[8];
    int n, max_h, max_v, pend_bad, last_ls, interval, ls_bad, vs_cnt, hs_cnt, hs_low, de_cnt;
    bit fs_seen, prev_ls;
    tiny = '{4, 1, 1, 1, 2, 1, 1, 1};
    d_arst = 1'b1; d_pix = 1'b1; d_we = 1'b0; d_addr = 3'd0; d_data = 12'd0; d_commit = 1'b0;
    s_arst = 1'b1; s_pix = 1'b0; s_we = 1'b0; s_addr = 3'd0; s_data = 12'd0; s_commit = 1'b0;
    repeat (2) @(negedge clk);

    // default instance: reset values, hsync window, write + commit then async reset at (300,1)
    check("def_reset", {d_h, d_v, d_hs, d_vs, d_de, d_ls, d_fs, d_pend}, def_exp(0, 1'b0));
    d_arst = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      check("def_run", {d_h, d_v, d_hs, d_vs, d_de, d_ls, d_fs, d_pend}, def_exp(k, k > 500));
      d_we = (k == 200); d_addr = 3'd0; d_data = 12'd100;
      d_commit = (k == 500);
      @(negedge clk);
    end
    d_we = 1'b0; d_commit = 1'b0;
    check("def_at_300_1", {d_h, d_v, d_hs, d_vs, d_de, d_ls, d_fs, d_pend}, def_exp(1100, 1'b1));
    #2 d_arst = 1'b1;
    #1 check("def_arst", {d_h, d_v, d_hs, d_vs, d_de, d_ls, d_fs, d_pend}, def_exp(0, 1'b0));
    @(negedge clk);
    d_arst = 1'b0;
    hs_low = 0; de_cnt = 0; n = 0;
    for (int k = 0; k < 900; k++) begin
      check("def_after_rst", {d_h, d_v, d_hs, d_vs, d_de, d_ls, d_fs, d_pend}, def_exp(k, 1'b0));
      if (k < 800 && !d_hs) hs_low++;
      if (k < 800 && d_de) de_cnt++;
      if (d_ls) n++;
      @(negedge clk);
    end
    check_int("def_hsync_width", hs_low, 96);
    check_int("def_de_per_line", de_cnt, 640);
    check_int("def_linestarts", n, 1);

    // small instance: reset values, then pending writes must not disturb the frame
    s_arst = 1'b0;
    model_reset();
    sml_cmp("sml_reset");
    for (int i = 0; i < 320; i++)
      cyc(1'b1, $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), 12'($urandom_range(0, 15)),
          1'b0, "sml_pendwr");

    // tiny 4x2 mode committed mid-frame
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 3'(i), 12'(tiny[i]), 1'b0, "sml_wrtiny");
    cyc(1'b1, 1'b0, 3'd0, 12'd0, 1'b1, "sml_commit");
    check_int("sml_pend_set", int'(s_pend), 1);
    fs_seen = 0; pend_bad = 0;
    for (int i = 0; i < 200 && !fs_seen; i++) begin
      cyc(1'b1, 1'b0, 3'd0, 12'd0, 1'b0, "sml_oldframe");
      if (s_fs) fs_seen = 1;
      else if (s_pend !== 1'b1) pend_bad++;
    end
    check_int("sml_wrap_seen", int'(fs_seen), 1);
    check_int("sml_pend_held", pend_bad, 0);
    check_int("sml_pend_clr", int'(s_pend), 0);
    n = 0; max_h = 0; max_v = 0; fs_seen = 0;
    for (int i = 0; i < 100 && !fs_seen; i++) begin
      cyc(1'b1, 1'b0, 3'd0, 12'd0, 1'b0, "sml_tiny");
      n++;
      if (int'(s_h) > max_h) max_h = int'(s_h);
      if (int'(s_v) > max_v) max_v = int'(s_v);
      if (s_fs) fs_seen = 1;
    end
    check_int("sml_tiny_period", n, 35);
    check_int("sml_tiny_maxh", max_h, 6);
    check_int("sml_tiny_maxv", max_v, 4);

    // shrink HTOTAL 7 -> 5 with the commit in the wrap cycle itself
    cyc(1'b1, 1'b1, 3'd0, 12'd2, 1'b0, "sml_wrshrink");
    for (int i = 0; i < 60 && !(mh == 6 && mv == 4); i++)
      cyc(1'b1, 1'b0, 3'd0, 12'd0, 1'b0, "sml_tolast");
    check_int("sml_prewrap_h", int'(s_h), 6);
    cyc(1'b1, 1'b0, 3'd0, 12'd0, 1'b1, "sml_wrapcommit");
    check_int("sml_wrapcommit_pend", int'(s_pend), 0);
    max_h = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1'b1, 1'b0, 3'd0, 12'd0, 1'b0, "sml_shrunk");
      if (int'(s_h) > max_h) max_h = int'(s_h);
    end
    check_int("sml_shrink_maxh", max_h, 4);

    // pixel enable every 4th clock
    last_ls = -1; interval = 0; ls_bad = 0; prev_ls = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(i % 4 == 0, 1'b0, 3'd0, 12'd0, 1'b0, "sml_pix4");
      if (s_ls && prev_ls) ls_bad++;
      if (s_ls) begin
        if (last_ls >= 0 && interval == 0) interval = i - last_ls;
        last_ls = i;
      end
      prev_ls = s_ls;
    end
    check_int("sml_ls_interval", interval, 20);
    check_int("sml_ls_width", ls_bad, 0);

    // zero-width vsync with active-high polarity
    cyc(1'b1, 1'b1, 3'd6, 12'd0, 1'b0, "sml_wrvsyn0");
    cyc(1'b1, 1'b0, 3'd0, 12'd0, 1'b1, "sml_commitvsyn0");
    for (int i = 0; i < 100 && s_pend; i++) cyc(1'b1, 1'b0, 3'd0, 12'd0, 1'b0, "sml_waitvsyn0");
    check_int("sml_vsyn0_applied", int'(s_pend), 0);
    vs_cnt = 0; hs_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1'b1, 1'b0, 3'd0, 12'd0, 1'b0, "sml_vsyn0");
      if (s_vs) vs_cnt++;
      if (s_hs) hs_cnt++;
    end
    check_int("sml_vsync_never", vs_cnt, 0);
    check_int("sml_hsync_high_cnt", hs_cnt, 12);

    // randomized traffic, including zero-length fields and stalled pixels
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
          12'($urandom_range(0, 6)), $urandom_range(0, 19) == 0, "sml_rand");

    // async reset with a commit outstanding
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 3'(i), 12'(tiny[i]), 1'b0, "sml_prerst_wr");
    cyc(1'b0, 1'b0, 3'd0, 12'd0, 1'b1, "sml_prerst_commit");
    check_int("sml_prerst_pend", int'(s_pend), 1);
    #2 s_arst = 1'b1;
    model_reset();
    #1 sml_cmp("sml_arst");
    @(negedge clk);
    s_arst = 1'b0;
    check_int("sml_pend_dropped", int'(s_pend), 0);
    for (int i = 0; i < 200; i++) cyc(1'b1, 1'b0, 3'd0, 12'd0, 1'b0, "sml_postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
